led_source_sequencer: RTL and testbench

- Controller that decides which of two 8-bit sources drives the board LEDs. It replaces direct raw-button selection of the LED output.
- Conditions the raw push-button with a synchronizer, a debouncer and rising-edge detection.
- Runs a two-state select FSM. The select is either toggled manually by button presses or auto-alternated on a dwell timer.
- Produces a registered LED bus plus a select-change pulse. Sits between switch/counter sources and the LED pins.

---
 rtl/led_source_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_source_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_source_sequencer.sv
// Chooses which of two 8-bit sources drives the LEDs: debounced button toggles or a dwell timer alternates.
// Optional feature macro SWITCH_BLANK_EN: blank the LEDs for BLANK_CYCLES cycles on every source switch.
module led_source_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DWELL_CYCLES    = 100000000,
    parameter int BLANK_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       auto_en,
    input  logic [7:0] I0,
    input  logic [7:0] I1,
    output logic [7:0] led,
    output logic       sel,
    output logic       sel_changed
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DWELL_CYCLES < 2 || BLANK_CYCLES < 1) begin : g_param_check
        $error("led_source_sequencer: parameter below its minimum");
    end

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic            press;
    logic [DB_W-1:0] db_cnt;
    logic [DW_W-1:0] dwell_cnt;
    logic            dwell_done;
    logic            toggle;

    // Stage: two-flop synchronizer, debounce counter and registered press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            press  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= sync2;
                db_cnt <= '0;
                press  <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A press and a dwell expiry landing together merge into one toggle.
    assign dwell_done = auto_en && (dwell_cnt == DW_LAST);
    assign toggle     = press || dwell_done;

`ifdef SWITCH_BLANK_EN
    localparam int BL_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {SHOW0, SHOW1, BLANK0, BLANK1} state_t;
    state_t          state;
    logic [BL_W-1:0] blank_cnt;

    // Stage: select FSM with blanking, dwell timer and registered LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SHOW0;
            sel         <= 1'b0;
            sel_changed <= 1'b0;
            led         <= 8'h00;
            dwell_cnt   <= '0;
            blank_cnt   <= '0;
        end else begin
            sel_changed <= 1'b0;
            led         <= sel ? I1 : I0;
            dwell_cnt   <= (auto_en && !toggle) ? dwell_cnt + 1'b1 : '0;
            case (state)
                SHOW0: begin
                    if (toggle) begin
                        state       <= BLANK1;
                        sel         <= 1'b1;
                        sel_changed <= 1'b1;
                        blank_cnt   <= '0;
                    end
                end
                SHOW1: begin
                    if (toggle) begin
                        state       <= BLANK0;
                        sel         <= 1'b0;
                        sel_changed <= 1'b1;
                        blank_cnt   <= '0;
                    end
                end
                BLANK0, BLANK1: begin
                    // Toggles are dropped here; dwell restarts only once a source is shown.
                    led       <= 8'h00;
                    dwell_cnt <= '0;
                    if (blank_cnt == BL_LAST) begin
                        state <= (state == BLANK1) ? SHOW1 : SHOW0;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                default: state <= SHOW0;
            endcase
        end
    end
`else
    typedef enum logic {SHOW0, SHOW1} state_t;
    state_t state;

    // Stage: select FSM, dwell timer and registered LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SHOW0;
            sel         <= 1'b0;
            sel_changed <= 1'b0;
            led         <= 8'h00;
            dwell_cnt   <= '0;
        end else begin
            sel_changed <= 1'b0;
            led         <= sel ? I1 : I0;
            dwell_cnt   <= (auto_en && !toggle) ? dwell_cnt + 1'b1 : '0;
            case (state)
                SHOW0: begin
                    if (toggle) begin
                        state       <= SHOW1;
                        sel         <= 1'b1;
                        sel_changed <= 1'b1;
                    end
                end
                SHOW1: begin
                    if (toggle) begin
                        state       <= SHOW0;
                        sel         <= 1'b0;
                        sel_changed <= 1'b1;
                    end
                end
                default: state <= SHOW0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_led_source_sequencer.sv
// Directed bench for led_source_sequencer with short debounce/dwell/blank settings.
module tb_led_source_sequencer;
    localparam int DB = 4;
    localparam int DW = 16;
    localparam int BL = 2;
`ifdef SWITCH_BLANK_EN
    localparam int GAP = DW + BL;
    localparam logic [7:0] SWITCH_LED = 8'h00;
`else
    localparam int GAP = DW;
    localparam logic [7:0] SWITCH_LED = 8'h3C;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       auto_en;
    logic [7:0] i0;
    logic [7:0] i1;
    logic [7:0] led;
    logic       sel;
    logic       sel_changed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_source_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .DWELL_CYCLES   (DW),
        .BLANK_CYCLES   (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .auto_en    (auto_en),
        .I0         (i0),
        .I1         (i1),
        .led        (led),
        .sel        (sel),
        .sel_changed(sel_changed)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_changes(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick(1);
            if (sel_changed) cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; auto_en = 1'b0; i0 = 8'hA5; i1 = 8'h3C;
        tick(1);
        checks++;
        if ({led, sel, sel_changed} !== 10'h000) begin
            errors++;
            $display("FAIL reset_first led=%h sel=%b chg=%b want 00/0/0", led, sel, sel_changed);
        end
        tick(2);
        checks++;
        if ({led, sel, sel_changed} !== 10'h000) begin
            errors++;
            $display("FAIL reset_held led=%h sel=%b chg=%b want 00/0/0", led, sel, sel_changed);
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (led !== 8'hA5) begin
            errors++;
            $display("FAIL reset_release_led got %h want a5", led);
        end
    endtask

    task automatic test_manual_press();
        int c;
        btn = 1'b1;
        tick(6);
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL press_early sel got %b want 0", sel);
        end
        tick(1);
        checks++;
        if ({sel, sel_changed, led} !== {2'b11, 8'hA5}) begin
            errors++;
            $display("FAIL press_edge sel=%b chg=%b led=%h want 1/1/a5", sel, sel_changed, led);
        end
        tick(1);
        checks++;
        if ({sel_changed, led} !== {1'b0, SWITCH_LED}) begin
            errors++;
            $display("FAIL press_after chg=%b led=%h want 0/%h", sel_changed, led, SWITCH_LED);
        end
        btn = 1'b0;
        count_changes(12, c);
        checks++;
        if (c !== 0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL release_no_toggle changes=%0d sel=%b want 0/1", c, sel);
        end
    endtask

    task automatic test_bounce();
        int c;
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1; tick(1);
        btn = 1'b0;
        count_changes(12, c);
        checks++;
        if (c !== 0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL bounce_ignored changes=%0d sel=%b want 0/1", c, sel);
        end
        btn = 1'b1;
        count_changes(12, c);
        checks++;
        if (c !== 1 || sel !== 1'b0) begin
            errors++;
            $display("FAIL clean_press changes=%0d sel=%b want 1/0", c, sel);
        end
        btn = 1'b0;
        count_changes(12, c);
        checks++;
        if (c !== 0) begin
            errors++;
            $display("FAIL clean_release changes=%0d want 0", c);
        end
    endtask

    task automatic test_auto();
        int c;
        logic exp_sel;
        logic exp_chg;
        exp_sel = 1'b0;
        auto_en = 1'b1;
        for (int k = 1; k <= DW + 2 * GAP; k++) begin
            tick(1);
            exp_chg = (k == DW) || (k == DW + GAP) || (k == DW + 2 * GAP);
            if (exp_chg) exp_sel = ~exp_sel;
            checks++;
            if ({sel, sel_changed} !== {exp_sel, exp_chg}) begin
                errors++;
                $display("FAIL auto_k%0d sel=%b chg=%b want %b/%b", k, sel, sel_changed, exp_sel, exp_chg);
            end
        end
        auto_en = 1'b0;
        tick(2);
        checks++;
        if (dut.dwell_cnt !== '0) begin
            errors++;
            $display("FAIL auto_off_dwell got %0d want 0", dut.dwell_cnt);
        end
        count_changes(40, c);
        checks++;
        if (c !== 0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL auto_off_hold changes=%0d sel=%b want 0/1", c, sel);
        end
    endtask

    task automatic test_collision();
        int c;
        auto_en = 1'b1;
        tick(9);
        btn = 1'b1;
        tick(7);
        checks++;
        if ({sel, sel_changed} !== 2'b01) begin
            errors++;
            $display("FAIL collide_toggle sel=%b chg=%b want 0/1", sel, sel_changed);
        end
        count_changes(GAP - 1, c);
        checks++;
        if (c !== 0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL collide_single changes=%0d sel=%b want 0/0", c, sel);
        end
        tick(1);
        checks++;
        if ({sel, sel_changed} !== 2'b11) begin
            errors++;
            $display("FAIL collide_next_auto sel=%b chg=%b want 1/1", sel, sel_changed);
        end
        auto_en = 1'b0;
        btn = 1'b0;
        tick(12);
    endtask

    task automatic test_held_through_reset();
        int c;
        rst = 1'b1;
        btn = 1'b1;
        tick(3);
        rst = 1'b0;
        count_changes(15, c);
        checks++;
        if (c !== 1 || sel !== 1'b1) begin
            errors++;
            $display("FAIL held_reset changes=%0d sel=%b want 1/1", c, sel);
        end
        btn = 1'b0;
        tick(12);
    endtask

`ifdef SWITCH_BLANK_EN
    task automatic test_blank();
        int c;
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(1);
        btn = 1'b1;
        tick(7);
        checks++;
        if ({sel, sel_changed, led} !== {2'b11, 8'hA5}) begin
            errors++;
            $display("FAIL blank_enter sel=%b chg=%b led=%h want 1/1/a5", sel, sel_changed, led);
        end
        tick(1);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL blank_c1 led=%h want 00", led);
        end
        tick(1);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL blank_c2 led=%h want 00", led);
        end
        tick(1);
        checks++;
        if (led !== 8'h3C) begin
            errors++;
            $display("FAIL blank_exit led=%h want 3c", led);
        end
        btn = 1'b0;
        tick(12);
        // Auto expiry enters the blank; a press pulse then lands inside it.
        auto_en = 1'b1;
        tick(10);
        btn = 1'b1;
        tick(6);
        checks++;
        if ({sel, sel_changed} !== 2'b01) begin
            errors++;
            $display("FAIL blank_auto_enter sel=%b chg=%b want 0/1", sel, sel_changed);
        end
        tick(1);
        auto_en = 1'b0;
        checks++;
        if ({sel, sel_changed, led} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL blank_press_ignored sel=%b chg=%b led=%h want 0/0/00", sel, sel_changed, led);
        end
        tick(2);
        checks++;
        if ({sel, led} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL blank_press_exit sel=%b led=%h want 0/a5", sel, led);
        end
        btn = 1'b0;
        count_changes(12, c);
        checks++;
        if (c !== 0) begin
            errors++;
            $display("FAIL blank_press_leak changes=%0d want 0", c);
        end
        btn = 1'b1;
        tick(7);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({sel, sel_changed, led} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL blank_reset sel=%b chg=%b led=%h want 0/0/00", sel, sel_changed, led);
        end
        rst = 1'b0;
        btn = 1'b0;
        count_changes(12, c);
        checks++;
        if (c !== 0 || led !== 8'hA5) begin
            errors++;
            $display("FAIL blank_reset_after changes=%0d led=%h want 0/a5", c, led);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_manual_press();
        test_bounce();
        test_auto();
        test_collision();
        test_held_through_reset();
`ifdef SWITCH_BLANK_EN
        test_blank();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
